// File: rtl/sdram_wr_burst.sv
// Write-side front end for sdram_ctl: a word FIFO feeding a 4-word burst packer.
// Each burst is presented with a start address that advances (with explicit wrap) on every acknowledge.
module sdram_wr_burst #(
    parameter int                DATA_W     = 16,
    parameter int                BURST_LEN  = 4,
    parameter int                FIFO_DEPTH = 16,
    parameter int                ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] ADDR_BASE  = '0,
    parameter logic [ADDR_W-1:0] ADDR_LAST  = 22'h3FFFFC
) (
    input  logic                          clock,
    input  logic                          srst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [BURST_LEN*DATA_W-1:0]   burst_data,
    output logic [BURST_LEN-1:0]          burst_mask,
    output logic [ADDR_W-1:0]             burst_addr,
    output logic                          burst_en,
    input  logic                          burst_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

    state_t                        state_q, state_d;
    logic [DATA_W-1:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]              level_q, level_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [BURST_LEN*DATA_W-1:0]   data_q, data_d;
    logic [BURST_LEN-1:0]          mask_q, mask_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          ovf_q, ovf_d;
    logic                          fp_q, fp_d;
    logic [LVL_W-1:0]              frem_q, frem_d;
    logic [LVL_W-1:0]              frem_dec;
    logic                          push, pop, load_done;

    // A pop in the same cycle frees a slot, so a full FIFO can still take a word while loading.
    always_comb begin
        pop      = (state_q == LOAD) && (level_q != '0);
        in_ready = (level_q < LVL_W'(FIFO_DEPTH)) || pop;
        push     = in_valid && in_ready;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
        ovf_d     = ovf_q | (in_valid & ~in_ready);
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        load_done = (state_q == LOAD) && (idx_q == IDX_W'(BURST_LEN - 1));

        case (state_q)
            IDLE: begin
                if ((level_q >= LVL_W'(BURST_LEN)) || (fp_q && (level_q != '0))) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                // An empty FIFO here only happens while flushing; the slot becomes padding.
                for (int k = 0; k < BURST_LEN; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        data_d[k*DATA_W +: DATA_W] = pop ? mem_q[rd_ptr_q] : '0;
                        mask_d[k]                  = pop;
                    end
                end
                idx_d = idx_q + IDX_W'(1);
                if (load_done) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (burst_ack) begin
                    state_d = IDLE;
                    addr_d  = (addr_q == ADDR_LAST) ? ADDR_BASE : addr_q + ADDR_W'(BURST_LEN);
                end
            end
            default: state_d = IDLE;
        endcase

        // frem counts words that were in the FIFO when flush arrived and are not yet loaded.
        frem_dec = (pop && (frem_q != '0)) ? frem_q - LVL_W'(1) : frem_q;
        frem_d   = frem_dec;
        fp_d     = fp_q;
        if (fp_q && (frem_dec == '0) && (load_done || ((state_q != LOAD) && (level_q == '0)))) begin
            fp_d = 1'b0;
        end
        if (flush && !((level_q == '0) && (state_q != LOAD))) begin
            fp_d   = 1'b1;
            frem_d = level_q - LVL_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (srst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            addr_q   <= ADDR_BASE;
            ovf_q    <= 1'b0;
            fp_q     <= 1'b0;
            frem_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
            fp_q     <= fp_d;
            frem_q   <= frem_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign burst_data = data_q;
    assign burst_mask = mask_q;
    assign burst_addr = addr_q;
    assign burst_en   = (state_q == PRESENT);
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule
